regfile_wb_sequencer: RTL

Write-back sequencer and scoreboard that drives the write port of the CPU register file. It accepts completed results from execution units into a small FIFO and retires one result per cycle to the register file. It tracks in-flight destination registers and blocks issue of any instruction whose sources or destination are still pending, covering RAW and WAW hazards.

---
 rtl/regfile_wb_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer for the register file: queues execution results in a small FIFO,
// retires one per cycle, and keeps a busy scoreboard that blocks RAW/WAW hazards at issue.
module regfile_wb_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_ready,
  input  logic        result_valid,
  input  logic [4:0]  result_rd,
  input  logic [31:0] result_data,
  output logic        result_ready,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_din,
  output logic        rf_rw,
  output logic        rf_enable,
  output logic [31:0] busy,
  output logic        err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, issue_fire, orphan;
  logic [31:0]   busy_set, busy_clr, busy_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign result_ready = !full;
  assign push         = result_valid && result_ready && (result_rd != 5'd0);
  assign pop          = !empty;
  assign orphan       = push && !busy[result_rd];

  assign issue_ready = !(busy[issue_rs1] | busy[issue_rs2] | (issue_wr & busy[issue_rd]));
  assign issue_fire  = issue_valid && issue_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_fire && issue_wr && (issue_rd != 5'd0)) busy_set[issue_rd] = 1'b1;
    if (rf_rw) busy_clr[rf_rd] = 1'b1;
  end

  // Set is applied after clear so it wins if both ever hit the same bit; x0 never goes busy.
  assign busy_next = ((busy & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;

  // NOTE: the FIFO storage is deliberately not reset; only the pointers define valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[AW-1:0]]   <= result_rd;
      fifo_data[wr_ptr[AW-1:0]] <= result_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      busy       <= '0;
      rf_rw      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_din     <= 32'd0;
      rf_enable  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      rf_enable <= 1'b1;
      busy      <= busy_next;
      rf_rw     <= pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        rf_rd  <= fifo_rd[rd_ptr[AW-1:0]];
        rf_din <= fifo_data[rd_ptr[AW-1:0]];
      end
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule
